// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction ROM port, redirect input and decode handshake.
// master = fetch queue, slave = surrounding core / ROM.
interface inst_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   instrom_openmips_data;
  logic [31:0]   openmips_instrom_addr;
  logic          openmips_instrom_ren;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          id_ready;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic [31:0]   if_pc;
  logic [CW-1:0] q_count;

  modport master (
    input  instrom_openmips_data, redirect_valid, redirect_pc, id_ready,
    output openmips_instrom_addr, openmips_instrom_ren, if_valid, if_inst, if_pc, q_count
  );

  modport slave (
    output instrom_openmips_data, redirect_valid, redirect_pc, id_ready,
    input  openmips_instrom_addr, openmips_instrom_ren, if_valid, if_inst, if_pc, q_count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, reads the ROM, buffers {pc,inst} for decode.
// Optional FETCH_BYPASS_EN presents the ROM word straight to decode when the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_queue_if.master  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  entry_t head_e;
  logic   q_vld;
  logic   q_pop;
  logic   ren;
  logic   byp;
  logic   push;
  logic   unused_pc_lsb;

  assign unused_pc_lsb = ^bus.redirect_pc[1:0];
  assign head_e        = mem_q[head_q];

  // Queue head is visible unless a redirect is killing it this cycle.
  assign q_vld = !rst && !bus.redirect_valid && (count_q != '0);
  assign q_pop = q_vld && bus.id_ready;
  assign ren   = !rst && !bus.redirect_valid && ((count_q != FULL) || q_pop);

`ifdef FETCH_BYPASS_EN
  assign byp = ren && (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  // A bypassed word taken by decode the same cycle never lands in storage.
  assign push = ren && !(byp && bus.id_ready);

  assign bus.openmips_instrom_addr = fetch_pc_q;
  assign bus.openmips_instrom_ren  = ren;
  assign bus.q_count               = rst ? '0 : count_q;

  always_comb begin
    bus.if_valid = 1'b0;
    bus.if_inst  = 32'h0;
    bus.if_pc    = 32'h0;
    if (byp) begin
      bus.if_valid = 1'b1;
      bus.if_inst  = bus.instrom_openmips_data;
      bus.if_pc    = fetch_pc_q;
    end else if (q_vld) begin
      bus.if_valid = 1'b1;
      bus.if_inst  = head_e.inst;
      bus.if_pc    = head_e.pc;
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (push)  tail_d = tail_q + 1'b1;
      if (q_pop) head_d = head_q + 1'b1;
      // Natural 32-bit wrap takes 0xFFFF_FFFC to 0.
      if (ren)   fetch_pc_d = fetch_pc_q + 32'd4;
      unique case ({push, q_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= entry_t'{pc: fetch_pc_q, inst: bus.instrom_openmips_data};
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed phases queue expected PCs, a negedge monitor
// checks every accepted decode handshake in order; direct checks cover reset, full and redirect.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] sb[$];

  inst_fetch_queue_if #(.DEPTH(DEPTH)) bus();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ROM word differs from its address so pc/inst mix-ups are visible.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.instrom_openmips_data = rom(bus.openmips_instrom_addr);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (sb.size() != 0 && t < 60);
    chk("drain_left", 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] p = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // Monitor: every accepted handshake must match the next expected PC.
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.if_valid && bus.id_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop actual=%h required=none t=%0t", bus.if_pc, $time);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", bus.if_pc, e);
        chk("pop_inst", bus.if_inst, rom(e));
      end
    end else if (!bus.if_valid) begin
      chk("idle_inst", bus.if_inst, 32'h0);
      chk("idle_pc", bus.if_pc, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset held three cycles.
    repeat (3) begin
      step();
      @(negedge clk);
      chk("rst_ren", 32'(bus.openmips_instrom_ren), 32'h0);
      chk("rst_valid", 32'(bus.if_valid), 32'h0);
      chk("rst_count", 32'(bus.q_count), 32'h0);
    end
    push_seq(32'h0, 8);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("c0_addr", bus.openmips_instrom_addr, 32'h0);
    chk("c0_ren", 32'(bus.openmips_instrom_ren), 32'h1);
    chk("c0_valid", 32'(bus.if_valid), 32'(BYP));
    step();
    @(negedge clk);
    chk("c1_valid", 32'(bus.if_valid), 32'h1);
    chk("c1_pc", bus.if_pc, BYP ? 32'h4 : 32'h0);
    drain();
    step(); bus.id_ready = 1'b0;

    // Partially fill, then reset mid-operation.
    repeat (2) step();
    @(negedge clk);
    chk("pre_rst_count", 32'(bus.q_count), BYP ? 32'h2 : 32'h3);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ren", 32'(bus.openmips_instrom_ren), 32'h0);
    chk("mid_rst_count", 32'(bus.q_count), 32'h0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 32'(bus.q_count), 32'h0);
    chk("post_rst_addr", bus.openmips_instrom_addr, 32'h0);
    chk("post_rst_valid", 32'(bus.if_valid), 32'(BYP));

    // Fill to full with decode stalled.
    repeat (4) step();
    @(negedge clk);
    chk("full_count", 32'(bus.q_count), 32'h4);
    chk("full_ren", 32'(bus.openmips_instrom_ren), 32'h0);
    chk("full_addr", bus.openmips_instrom_addr, 32'h10);
    chk("full_head_pc", bus.if_pc, 32'h0);
    chk("full_head_inst", bus.if_inst, rom(32'h0));
    push_seq(32'h0, 5);
    step(); bus.id_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_count", 32'(bus.q_count), 32'h4);
    chk("full_pop_ren", 32'(bus.openmips_instrom_ren), 32'h1);
    drain();
    step(); bus.id_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("refill_count", 32'(bus.q_count), 32'h4);

    // Redirect from a full queue; low PC bits are dropped.
    push_seq(32'h100, 4);
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103; bus.id_ready = 1'b1;
    @(negedge clk);
    chk("redir_valid", 32'(bus.if_valid), 32'h0);
    chk("redir_ren", 32'(bus.openmips_instrom_ren), 32'h0);
    step(); bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_count", 32'(bus.q_count), 32'h0);
    chk("redir_addr", bus.openmips_instrom_addr, 32'h100);
    chk("redir_c1_valid", 32'(bus.if_valid), 32'(BYP));
    step();
    @(negedge clk);
    chk("redir_c2_valid", 32'(bus.if_valid), 32'h1);
    chk("redir_c2_pc", bus.if_pc, BYP ? 32'h104 : 32'h100);
    drain();
    step(); bus.id_ready = 1'b0;

    // Back-to-back redirects: only the second target is ever presented.
    push_seq(32'h300, 3);
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; bus.id_ready = 1'b1;
    step(); bus.redirect_pc = 32'h300;
    step(); bus.redirect_valid = 1'b0;
    drain();
    step(); bus.id_ready = 1'b0;

    // Fetch PC wraps past the top of the address space.
    push_seq(32'hFFFF_FFF8, 4);
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8; bus.id_ready = 1'b1;
    step(); bus.redirect_valid = 1'b0;
    drain();
    step(); bus.id_ready = 1'b0;

    // Irregular decode stalls must not reorder or drop entries.
    push_seq(32'h400, 8);
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h400;
    step(); bus.redirect_valid = 1'b0;
    begin
      logic [7:0] pat = 8'b0110_1001;
      for (int i = 0; i < 8; i++) begin
        step(); bus.id_ready = pat[i];
      end
    end
    step(); bus.id_ready = 1'b1;
    drain();
    step(); bus.id_ready = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
